// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D memory port arbiter: FSM states, grant codes
// and the legal memory-latency range.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between the instruction and data requesters.
// Purely combinational; on a collision the side that did not win last time wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic [1:0] last_grant,
  output logic [1:0] pick
);

  always_comb begin
    pick = GNT_NONE;
    if (i_req && d_req) begin
      pick = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (i_req) begin
      pick = GNT_I;
    end else if (d_req) begin
      pick = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one synchronous
// single-port memory, inserting read wait states and returning a one-cycle ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX) || (MEM_LAT >= (1 << CNT_W)))
  begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT out of range or does not fit in CNT_W");
  end

  arb_state_e       state_q;
  logic [1:0]       last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       pick;

  arb_rr2 u_rr (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  // rst_n is active-high in this codebase despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_D;
      cnt_q        <= '0;
      grant        <= GNT_NONE;
      busy         <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick != GNT_NONE) begin
            grant        <= pick;
            last_grant_q <= pick;
            busy         <= 1'b1;
            mem_en       <= 1'b1;
            cnt_q        <= CNT_W'(MEM_LAT);
            state_q      <= ACCESS;
            if (pick == GNT_I) begin
              mem_addr <= i_addr;
              mem_we   <= 1'b0;
            end else begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end
          end
        end
        ACCESS: begin
          if (mem_we) begin
            // Writes complete after a single memory cycle; no data to capture.
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            i_ack   <= grant[0];
            d_ack   <= grant[1];
            state_q <= DONE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            mem_en <= 1'b0;
            if (grant[0]) begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
          grant   <= GNT_NONE;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          grant     <= GNT_NONE;
          busy      <= 1'b0;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          i_ack     <= 1'b0;
          d_ack     <= 1'b0;
          i_rdata   <= '0;
          d_rdata   <= '0;
        end
      endcase
    end
  end

endmodule
